// File: rtl/vx_mem_tag_remap_pkg.sv
// Shared defaults for the memory tag remapper.
// Slot count default and the derived controller-side tag width.
package vx_mem_tag_remap_pkg;

  localparam int VX_MEM_RMAP_SLOTS = 16;

  function automatic int rmap_tag_out_w(input int slots);
    return $clog2(slots);
  endfunction

endpackage

// File: rtl/vx_mem_tag_remap.sv
// Remaps wide Vortex memory tags onto narrow slot indices and back.
// Ports: req in/out (Vortex->ctrl), rsp in/out (ctrl->Vortex), pending_count, full.
module vx_mem_tag_remap
  import vx_mem_tag_remap_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int BYTEEN_WIDTH = DATA_WIDTH / 8,
  parameter int TAG_IN_WIDTH = 16,
  parameter int NUM_SLOTS    = VX_MEM_RMAP_SLOTS
) (
  input  logic                                 clk,
  input  logic                                 reset,

  input  logic                                 mem_req_valid_in,
  input  logic                                 mem_req_rw_in,
  input  logic [BYTEEN_WIDTH-1:0]              mem_req_byteen_in,
  input  logic [ADDR_WIDTH-1:0]                mem_req_addr_in,
  input  logic [DATA_WIDTH-1:0]                mem_req_data_in,
  input  logic [TAG_IN_WIDTH-1:0]              mem_req_tag_in,
  output logic                                 mem_req_ready_in,

  output logic                                 mem_req_valid_out,
  output logic                                 mem_req_rw_out,
  output logic [BYTEEN_WIDTH-1:0]              mem_req_byteen_out,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr_out,
  output logic [DATA_WIDTH-1:0]                mem_req_data_out,
  output logic [rmap_tag_out_w(NUM_SLOTS)-1:0] mem_req_tag_out,
  input  logic                                 mem_req_ready_out,

  input  logic                                 mem_rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]                mem_rsp_data_in,
  input  logic [rmap_tag_out_w(NUM_SLOTS)-1:0] mem_rsp_tag_in,
  output logic                                 mem_rsp_ready_in,

  output logic                                 mem_rsp_valid_out,
  output logic [DATA_WIDTH-1:0]                mem_rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]              mem_rsp_tag_out,
  input  logic                                 mem_rsp_ready_out,

  output logic [$clog2(NUM_SLOTS+1)-1:0]       pending_count,
  output logic                                 full
);

  localparam int TW = rmap_tag_out_w(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0]    free_mask_q, free_mask_d;
  logic [CW-1:0]           pend_q, pend_d;
  logic [TAG_IN_WIDTH-1:0] tag_table [NUM_SLOTS];

  logic [TW-1:0] alloc_idx;
  logic          alloc_ok;
  logic          rd_fire;
  logic          rsp_fire;

  // Lowest free slot wins.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_mask_q[i]) alloc_idx = TW'(i);
    end
  end

  assign full     = ~|free_mask_q;
  assign alloc_ok = mem_req_rw_in | ~full;

  assign mem_req_valid_out  = ~reset & mem_req_valid_in & alloc_ok;
  assign mem_req_ready_in   = ~reset & mem_req_ready_out & alloc_ok;
  assign mem_req_rw_out     = mem_req_rw_in;
  assign mem_req_byteen_out = mem_req_byteen_in;
  assign mem_req_addr_out   = mem_req_addr_in;
  assign mem_req_data_out   = mem_req_data_in;
  assign mem_req_tag_out    = mem_req_rw_in ? '0 : alloc_idx;

  assign mem_rsp_valid_out = ~reset & mem_rsp_valid_in;
  assign mem_rsp_ready_in  = ~reset & mem_rsp_ready_out;
  assign mem_rsp_data_out  = mem_rsp_data_in;
  assign mem_rsp_tag_out   = tag_table[mem_rsp_tag_in];

  assign rd_fire  = mem_req_valid_in & mem_req_ready_in
                  & ~mem_req_rw_in;
  assign rsp_fire = mem_rsp_valid_in & mem_rsp_ready_in;

  assign pending_count = pend_q;

  // Alloc and free never hit the same slot: the freed one is busy.
  always_comb begin
    free_mask_d = free_mask_q;
    if (rd_fire)  free_mask_d[alloc_idx]      = 1'b0;
    if (rsp_fire) free_mask_d[mem_rsp_tag_in] = 1'b1;
  end

  always_comb begin
    pend_d = pend_q;
    unique case ({rd_fire, rsp_fire})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_mask_q <= '1;
      pend_q      <= '0;
    end else begin
      free_mask_q <= free_mask_d;
      pend_q      <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire) tag_table[alloc_idx] <= mem_req_tag_in;
  end

  // Protocol checks; a stray response is still forwarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (rsp_fire) begin
        assert (!free_mask_q[mem_rsp_tag_in])
          else $error("rsp to free slot %0d", mem_rsp_tag_in);
      end
      assert (pend_q <= CW'(NUM_SLOTS))
        else $error("pending overflow");
      assert (full == (pend_q == CW'(NUM_SLOTS)))
        else $error("full/pending disagree");
    end
  end

endmodule

// File: tb/tb_vx_mem_tag_remap.sv
// Directed bench for vx_mem_tag_remap.
// Immediate assertions at each check, one linear stimulus sequence.
module tb_vx_mem_tag_remap;

  localparam int DW = 512;
  localparam int AW = 26;
  localparam int BW = DW / 8;
  localparam int TIW = 16;
  localparam int NS = 16;
  localparam int TOW = 4;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;
  logic req_valid_i, req_rw_i, req_ready_in;
  logic [BW-1:0] req_byteen_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_data_i;
  logic [TIW-1:0] req_tag_i;
  logic req_valid_o, req_rw_o, req_ready_o;
  logic [BW-1:0] req_byteen_o;
  logic [AW-1:0] req_addr_o;
  logic [DW-1:0] req_data_o;
  logic [TOW-1:0] req_tag_o;
  logic rsp_valid_i, rsp_ready_in;
  logic [DW-1:0] rsp_data_i;
  logic [TOW-1:0] rsp_tag_i;
  logic rsp_valid_o, rsp_ready_o;
  logic [DW-1:0] rsp_data_o;
  logic [TIW-1:0] rsp_tag_o;
  logic [CW-1:0] pend;
  logic full;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vx_mem_tag_remap dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid_in   (req_valid_i),
    .mem_req_rw_in      (req_rw_i),
    .mem_req_byteen_in  (req_byteen_i),
    .mem_req_addr_in    (req_addr_i),
    .mem_req_data_in    (req_data_i),
    .mem_req_tag_in     (req_tag_i),
    .mem_req_ready_in   (req_ready_in),
    .mem_req_valid_out  (req_valid_o),
    .mem_req_rw_out     (req_rw_o),
    .mem_req_byteen_out (req_byteen_o),
    .mem_req_addr_out   (req_addr_o),
    .mem_req_data_out   (req_data_o),
    .mem_req_tag_out    (req_tag_o),
    .mem_req_ready_out  (req_ready_o),
    .mem_rsp_valid_in   (rsp_valid_i),
    .mem_rsp_data_in    (rsp_data_i),
    .mem_rsp_tag_in     (rsp_tag_i),
    .mem_rsp_ready_in   (rsp_ready_in),
    .mem_rsp_valid_out  (rsp_valid_o),
    .mem_rsp_data_out   (rsp_data_o),
    .mem_rsp_tag_out    (rsp_tag_o),
    .mem_rsp_ready_out  (rsp_ready_o),
    .pending_count      (pend),
    .full               (full)
  );

  task automatic chk(input string nm,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rd(input logic [TIW-1:0] t);
    req_valid_i = 1'b1;
    req_rw_i    = 1'b0;
    req_tag_i   = t;
  endtask

  task automatic rsp(input logic [TOW-1:0] s);
    rsp_valid_i = 1'b1;
    rsp_tag_i   = s;
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
    req_rw_i    = 1'b0;
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    req_valid_i  = 1'b1;
    req_rw_i     = 1'b0;
    req_byteen_i = '1;
    req_addr_i   = 26'h0000040;
    req_data_i   = {16{32'hDEADBEEF}};
    req_tag_i    = 16'h0;
    req_ready_o  = 1'b1;
    rsp_valid_i  = 1'b1;
    rsp_data_i   = {16{32'hC0FFEE11}};
    rsp_tag_i    = '0;
    rsp_ready_o  = 1'b1;

    // Reset gating
    tick();
    chk("rst_req_valid", DW'(req_valid_o), DW'(0));
    chk("rst_req_ready", DW'(req_ready_in), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid_o), DW'(0));
    chk("rst_rsp_ready", DW'(rsp_ready_in), DW'(0));
    idle();
    reset = 1'b0;
    settle();
    chk("rst_pend", DW'(pend), DW'(0));
    chk("rst_full", DW'(full), DW'(0));

    // Three reads, out-of-order responses
    for (int i = 0; i < 3; i++) begin
      rd(16'h0A01 + 16'(i));
      settle();
      chk("rd3_tag", DW'(req_tag_o), DW'(i));
      chk("rd3_ready", DW'(req_ready_in), DW'(1));
      chk("rd3_data", req_data_o, {16{32'hDEADBEEF}});
      tick();
    end
    idle();
    settle();
    chk("rd3_pend", DW'(pend), DW'(3));
    rsp(4'd1);
    settle();
    chk("rsp1_tag", DW'(rsp_tag_o), DW'(16'h0A02));
    chk("rsp1_data", rsp_data_o, {16{32'hC0FFEE11}});
    chk("rsp1_valid", DW'(rsp_valid_o), DW'(1));
    tick();
    rsp(4'd0);
    settle();
    chk("rsp0_tag", DW'(rsp_tag_o), DW'(16'h0A01));
    tick();
    rsp(4'd2);
    settle();
    chk("rsp2_tag", DW'(rsp_tag_o), DW'(16'h0A03));
    tick();
    idle();
    settle();
    chk("rsp3_pend", DW'(pend), DW'(0));

    // Fill all slots
    for (int i = 0; i < NS; i++) begin
      rd(16'h1000 + 16'(i));
      settle();
      chk("fill_tag", DW'(req_tag_o), DW'(i));
      tick();
    end
    chk("fill_full", DW'(full), DW'(1));
    chk("fill_pend", DW'(pend), DW'(16));
    rd(16'h1111);
    settle();
    chk("full_rd_ready", DW'(req_ready_in), DW'(0));
    chk("full_rd_valid", DW'(req_valid_o), DW'(0));

    // Write flows while full
    req_rw_i   = 1'b1;
    req_addr_i = 26'h100;
    settle();
    chk("full_wr_valid", DW'(req_valid_o), DW'(1));
    chk("full_wr_ready", DW'(req_ready_in), DW'(1));
    chk("full_wr_tag", DW'(req_tag_o), DW'(0));
    chk("full_wr_addr", DW'(req_addr_o), DW'(26'h100));
    tick();
    chk("wr_pend", DW'(pend), DW'(16));

    // Response on slot 5 while the read waits
    rd(16'h1111);
    rsp(4'd5);
    settle();
    chk("s5_ready", DW'(req_ready_in), DW'(0));
    chk("s5_rsp_tag", DW'(rsp_tag_o), DW'(16'h1005));
    tick();
    rsp_valid_i = 1'b0;
    settle();
    chk("s5_pend", DW'(pend), DW'(15));
    chk("s5_rd_ready", DW'(req_ready_in), DW'(1));
    chk("s5_rd_tag", DW'(req_tag_o), DW'(5));
    tick();
    chk("s5_full", DW'(full), DW'(1));
    chk("s5_pend2", DW'(pend), DW'(16));

    // Slot 3 freed while a read is pending
    rd(16'h2222);
    rsp(4'd3);
    settle();
    chk("s3_stall", DW'(req_ready_in), DW'(0));
    tick();
    rsp_valid_i = 1'b0;
    settle();
    chk("s3_tag", DW'(req_tag_o), DW'(3));
    chk("s3_ready", DW'(req_ready_in), DW'(1));
    tick();
    chk("s3_pend", DW'(pend), DW'(16));
    idle();

    // Free slot 0, then backpressure from controller
    rsp(4'd0);
    settle();
    chk("s0_rsp_tag", DW'(rsp_tag_o), DW'(16'h1000));
    tick();
    idle();
    req_ready_o = 1'b0;
    rd(16'h3333);
    req_addr_i = 26'h2AB;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("bp_valid", DW'(req_valid_o), DW'(1));
      chk("bp_ready", DW'(req_ready_in), DW'(0));
      chk("bp_addr", DW'(req_addr_o), DW'(26'h2AB));
      chk("bp_tag", DW'(req_tag_o), DW'(0));
      tick();
    end
    chk("bp_pend", DW'(pend), DW'(15));

    // Alloc slot 0 and free slot 7 in one cycle
    req_ready_o = 1'b1;
    rsp(4'd7);
    settle();
    chk("sim_ready", DW'(req_ready_in), DW'(1));
    chk("sim_rsp_tag", DW'(rsp_tag_o), DW'(16'h1007));
    tick();
    rsp_valid_i = 1'b0;
    rd(16'h4444);
    settle();
    chk("sim_pend", DW'(pend), DW'(15));
    chk("sim_full", DW'(full), DW'(0));
    chk("sim_next_tag", DW'(req_tag_o), DW'(7));
    idle();

    // Response backpressure on slot 9
    rsp_ready_o = 1'b0;
    rsp(4'd9);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("rbp_valid", DW'(rsp_valid_o), DW'(1));
      chk("rbp_ready", DW'(rsp_ready_in), DW'(0));
      tick();
    end
    chk("rbp_pend", DW'(pend), DW'(15));
    rsp_ready_o = 1'b1;
    settle();
    chk("rbp_ready_up", DW'(rsp_ready_in), DW'(1));
    chk("rbp_tag", DW'(rsp_tag_o), DW'(16'h1009));
    tick();
    idle();
    chk("rbp_pend2", DW'(pend), DW'(14));

    // Reset with outstanding reads
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(16'h5000 + 16'(i));
      tick();
    end
    idle();
    chk("r8_pend", DW'(pend), DW'(8));
    reset = 1'b1;
    rd(16'h6000);
    rsp(4'd2);
    settle();
    chk("mr_req_valid", DW'(req_valid_o), DW'(0));
    chk("mr_req_ready", DW'(req_ready_in), DW'(0));
    chk("mr_rsp_valid", DW'(rsp_valid_o), DW'(0));
    chk("mr_rsp_ready", DW'(rsp_ready_in), DW'(0));
    tick();
    reset = 1'b0;
    rsp_valid_i = 1'b0;
    settle();
    chk("mr_pend", DW'(pend), DW'(0));
    chk("mr_full", DW'(full), DW'(0));
    chk("mr_tag", DW'(req_tag_o), DW'(0));
    chk("mr_ready", DW'(req_ready_in), DW'(1));
    tick();
    idle();
    chk("mr_pend2", DW'(pend), DW'(1));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
